// File: rtl/mux_2_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin arbiter.
package mux_2_arbiter_pkg;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    typedef logic src_t;

    localparam int DATA_W = 16;

endpackage

// File: rtl/mux_2_arbiter_mux_2.sv
// Plain 2:1 data mux used as the arbiter's shared datapath.
module mux_2
    import mux_2_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic              i_sel,
    output logic [DATA_W-1:0] o_data
);

    assign o_data = i_sel ? i_data1 : i_data0;

endmodule

// File: rtl/mux_2_arbiter.sv
// Round-robin arbiter for two valid/ready sources into one registered output slot.
// Optional source locking is enabled by defining MUX_2_ARBITER_LOCK_EN.
module mux_2_arbiter
    import mux_2_arbiter_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int FAIR_RESET_SRC = 0
)
(
    input  logic             clk,
    input  logic             rst,
`ifdef MUX_2_ARBITER_LOCK_EN
    input  logic             in0_lock,
    input  logic             in1_lock,
`endif
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             mux_select
);

    generate
        if (WIDTH != DATA_W) begin : g_bad_width
            $error("mux_2_arbiter: WIDTH must equal 16");
        end
    endgenerate

    localparam src_t LAST_GRANT_RST = (FAIR_RESET_SRC == 0) ? 1'b1 : 1'b0;

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [WIDTH-1:0]   r_out_data;
    logic [WIDTH-1:0]   w_out_data_next;
    src_t               r_out_src;
    src_t               w_out_src_next;
    src_t               r_last_grant;
    src_t               w_last_grant_next;

    logic               w_slot_free;
    logic               w_req0;
    logic               w_req1;
    logic               w_grant_any;
    src_t               w_grant_idx;
    logic [WIDTH-1:0]   w_mux_data;

`ifdef MUX_2_ARBITER_LOCK_EN
    logic               r_lock_active;
    logic               w_lock_active_next;
    src_t               r_lock_owner;
    src_t               w_lock_owner_next;
    logic               w_grant_lock;

    // While locked, the non-owner's request is invisible to the arbiter.
    assign w_req0 = in0_valid & ~(r_lock_active & r_lock_owner);
    assign w_req1 = in1_valid & ~(r_lock_active & ~r_lock_owner);
    assign w_grant_lock = w_grant_idx ? in1_lock : in0_lock;
`else
    assign w_req0 = in0_valid;
    assign w_req1 = in1_valid;
`endif

    assign w_slot_free = ~rst & ((r_state == IDLE) | out_ready);
    assign w_grant_idx = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
    assign w_grant_any = w_slot_free & (w_req0 | w_req1);

    assign in0_ready  = w_grant_any & ~w_grant_idx;
    assign in1_ready  = w_grant_any &  w_grant_idx;
    assign mux_select = w_grant_any ? w_grant_idx : r_last_grant;

    mux_2 u_mux_2 (
        .i_data0 (in0_data),
        .i_data1 (in1_data),
        .i_sel   (mux_select),
        .o_data  (w_mux_data)
    );

    always_comb begin
        w_state_next      = r_state;
        w_out_data_next   = r_out_data;
        w_out_src_next    = r_out_src;
        w_last_grant_next = r_last_grant;
        if (w_grant_any) begin
            w_state_next      = HOLD;
            w_out_data_next   = w_mux_data;
            w_out_src_next    = w_grant_idx;
            w_last_grant_next = w_grant_idx;
        end else if ((r_state == HOLD) && out_ready) begin
            w_state_next = IDLE;
        end
    end

`ifdef MUX_2_ARBITER_LOCK_EN
    // Every transfer reloads the lock from the winner's lock bit.
    always_comb begin
        w_lock_active_next = r_lock_active;
        w_lock_owner_next  = r_lock_owner;
        if (w_grant_any) begin
            w_lock_active_next = w_grant_lock;
            w_lock_owner_next  = w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_active <= 1'b0;
            r_lock_owner  <= 1'b0;
        end else begin
            r_lock_active <= w_lock_active_next;
            r_lock_owner  <= w_lock_owner_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_out_data   <= '0;
            r_out_src    <= 1'b0;
            r_last_grant <= LAST_GRANT_RST;
        end else begin
            r_state      <= w_state_next;
            r_out_data   <= w_out_data_next;
            r_out_src    <= w_out_src_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
